// File: rtl/stream_dec_pkg.sv
// Shared types and helpers for the stream decryptor.
// Mode/state enums, default LFSR taps, word decrypt function.
package stream_dec_pkg;

  typedef enum logic {
    MODE_XOR = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  typedef enum logic {
    UNKEYED = 1'b0,
    RUN     = 1'b1
  } state_e;

  localparam logic [15:0] DEF_TAPS = 16'hB400;

  // Works on a wide container; callers keep the low DATA_W bits.
  // Low result bits depend only on low operand bits, so truncation
  // yields the mod 2^DATA_W result for both modes.
  function automatic logic [31:0] decrypt_word(
    input logic [31:0] data,
    input logic [31:0] ks,
    input mode_e       mode
  );
    logic [31:0] res;
    res = 32'd0;
    unique case (mode)
      MODE_XOR: res = data ^ ks;
      MODE_SUB: res = data - ks;
      default:  res = data ^ ks;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/stream_decryptor_lfsr_keystream.sv
// Galois LFSR keystream; steps only when asked, never idles forward.
// Ports: clk, rst, load, seed, step in; state out.
module lfsr_keystream
  import stream_dec_pkg::*;
#(
  parameter int          LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS = LFSR_W'(DEF_TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
    end else if (load) begin
      // All-zero is a lock-up state, substitute 1.
      r_state <= (seed == '0) ? LFSR_W'(1) : seed;
    end else if (step) begin
      r_state <= r_state[0] ? ((r_state >> 1) ^ TAPS)
                            : (r_state >> 1);
    end
  end

  assign state = r_state;

endmodule

// File: rtl/stream_decryptor.sv
// Streaming decryptor: cipher words in, plaintext out, LFSR keystream.
// Ports: clk, rst, key_load/key_seed, mode, in_* / out_* handshakes, keyed, word_count.
module stream_decryptor
  import stream_dec_pkg::*;
#(
  parameter int                DATA_W = 4,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS),
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_load,
  input  logic [LFSR_W-1:0] key_seed,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              keyed,
  output logic [CNT_W-1:0]  word_count
);

  state_e            r_state;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_count;
  logic [LFSR_W-1:0] w_lfsr;
  logic              w_ready;
  logic              w_accept;

  assign w_ready  = (r_state == RUN) & ~rst & ~key_load
                  & (~r_out_valid | out_ready);
  assign w_accept = in_valid & w_ready;

  lfsr_keystream #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (key_load),
    .seed  (key_seed),
    .step  (w_accept),
    .state (w_lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= UNKEYED;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_count     <= '0;
    end else if (key_load) begin
      r_state     <= RUN;
      r_out_valid <= 1'b0;
      r_count     <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= DATA_W'(decrypt_word(32'(in_data),
                                          32'(w_lfsr),
                                          mode_e'(mode)));
      if (r_count != '1)
        r_count <= r_count + 1'b1;
    end else if (r_out_valid & out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready   = w_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign keyed      = (r_state == RUN);
  assign word_count = r_count;

endmodule

// File: doc/stream_decryptor.md
Name: stream_decryptor

Overview:
- Parametrised, clocked successor to the 4-bit combinational decryption circuit.
- Decrypts a stream of DATA_W-bit cipher words against a keystream from a seeded Galois LFSR, using a valid/ready handshake on input and output.
- Two modes are selectable per word: XOR keystream, or subtract keystream modulo 2^DATA_W.
- Sits between a cipher-text source (file-driven bench or upstream encryptor) and the plaintext consumer.

Parameters:
- DATA_W, 4: cipher/plain word width; must be 1..LFSR_W.
- LFSR_W, 16: LFSR state width.
- TAPS, 16'hB400: Galois feedback mask, LFSR_W bits.
- CNT_W, 16: width of the decrypted-word counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- key_load  in  1  load key_seed into LFSR, arm block.
- key_seed  in  LFSR_W  LFSR seed.
- mode  in  1  0 = XOR, 1 = modular subtract; sampled with each accepted word.
- in_valid  in  1  cipher word present.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  DATA_W  cipher word.
- out_valid  out  1  plaintext word present.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  plaintext word.
- keyed  out  1  a key has been loaded since reset.
- word_count  out  CNT_W  words decrypted since last key load.

Behaviour:
- Reset (sync, rst=1 at clk edge): lfsr=0, keyed=0, out_valid=0, out_data=0, word_count=0. in_ready=0 while rst=1.
- States: UNKEYED (keyed=0), RUN (keyed=1).
  - UNKEYED->RUN on key_load.
  - RUN->RUN on key_load (re-key).
  - Any->UNKEYED only on rst.
- Key load, highest priority after rst:
  - lfsr <= key_seed, or 1 if key_seed==0, since the all-zero state is forbidden.
  - out_valid <= 0: a pending word is discarded.
  - word_count <= 0; keyed <= 1.
  - in_ready=0 in the key_load cycle.
- in_ready = keyed & !rst & !key_load & (!out_valid | out_ready). This is combinational; no combinational path from in_valid to in_ready.
- Accept = in_valid & in_ready. On accept:
  - ks = lfsr[DATA_W-1:0].
  - out_data <= mode ? (in_data - ks) mod 2^DATA_W : in_data ^ ks.
  - out_valid <= 1.
  - lfsr steps once: lsb=1 -> (lfsr>>1)^TAPS, else lfsr>>1.
  - word_count increments, saturating at all-ones.
- Latency: one cycle from accept to out_valid.
- Throughput: one word per cycle while out_ready=1.
- out_valid & out_ready with no accept -> out_valid <= 0.
- Simultaneous output handshake and accept -> out_valid stays 1 with the new word.
- Backpressure: out_valid=1 & out_ready=0 -> out_data/out_valid held stable; in_ready=0; LFSR does not step.
- in_valid while UNKEYED: ignored; in_ready=0, no LFSR step.
- LFSR steps only on accept, never on idle cycles. Keystream position therefore equals word_count (mod LFSR period).
- rst mid-stream: pending output dropped, keyed=0, and a new key_load is required before any data is accepted.

Decomposition:
- Package stream_dec_pkg:
  - mode_e enum (MODE_XOR=0, MODE_SUB=1).
  - state_e enum (UNKEYED, RUN).
  - Default TAPS constant 16'hB400.
  - Helper function decrypt_word(data, ks, mode).
- Sub-module lfsr_keystream:
  - Parameters LFSR_W, TAPS.
  - Ports: clk, rst, load, seed, step, state.
  - Owns zero-seed substitution.
- Top module: handshake, output register, counter, state.

Test Plan:
- Reset then in_valid=1, in_data=4'hB, no key_load for 5 cycles -> in_ready=0, out_valid=0, keyed=0, word_count=0.
- key_load with seed 16'hACE1, mode=0, in_data=4'hB then 4'h7, out_ready=1 -> out_data=4'hA (ks=1), then 4'h7 (ks=0, lfsr=16'hE270); word_count=2.
- Same seed, mode=1, in_data=4'h0 -> out_data=4'hF (0-1 wraps).
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles after the first word, in_valid held.
  - Response: out_data stable at 4'hA, in_ready=0, no LFSR step.
  - Then out_ready=1 -> second word 4'h7 appears next cycle, no word lost or duplicated.
- key_load=1 with key_seed=16'h0000 -> lfsr=16'h0001; first word in_data=4'h0, mode=0 -> out_data=4'h1.
- Re-key mid-stream while out_valid=1 & out_ready=0 -> out_valid drops next cycle, word_count=0, and the next word uses the low bits of the new seed.
